// File: rtl/nios_qsys_pio_in.sv
`default_nettype none
// ============================================================================
//  Module      : nios_qsys_pio_in
//  Description : Avalon-MM parallel input port with edge capture and a level
//                interrupt. Each input bit is synchronised by two flops and
//                compared against its previous synchronised value. Edges that
//                match EDGE_TYPE latch into EDGECAP. irq is asserted while any
//                captured edge is also enabled in IRQMASK.
//  Ports       : clk        - single clock
//                reset      - synchronous, active-high reset
//                address    - register select (0 DATA, 1 IRQMASK, 2 EDGECAP,
//                             3 reserved)
//                chipselect - slave select
//                write_n    - active-low write strobe
//                writedata  - write data
//                in_port    - asynchronous external inputs
//                readdata   - registered read data (zero-extended)
//                irq        - level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_qsys_pio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] c_ADDR_DATA    = 2'd0;
    localparam logic [1:0] c_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] c_ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] c_ARM_DONE     = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [1:0]       arm_q, arm_d;

    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic             w_write;
    logic             w_armed;
    logic             w_unused_wdata;

    // Upper write-data bits beyond WIDTH are intentionally ignored.
    assign w_unused_wdata = ^writedata;

    assign w_write = chipselect & ~write_n;

    // Capture stays disabled for the first edges after reset so that an input
    // already high at reset is not seen as a 0->1 transition by the flops.
    assign w_armed = (arm_q == c_ARM_DONE);

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = sync2_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~sync2_q & prev_q;
        end else begin : g_any
            assign w_edge = sync2_q ^ prev_q;
        end
    endgenerate

    assign w_clear = (w_write && address == c_ADDR_EDGECAP) ?
                     writedata[WIDTH-1:0] : '0;

    always_comb begin
        // Clear is applied first so a coincident new edge keeps the bit set.
        edgecap_d = (edgecap_q & ~w_clear) | (w_armed ? w_edge : '0);

        irqmask_d = irqmask_q;
        if (w_write && address == c_ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        arm_d = arm_q;
        if (!w_armed) begin
            arm_d = arm_q + 2'd1;
        end

        readdata_d = '0;
        case (address)
            c_ADDR_DATA:    readdata_d = 32'(sync2_q);
            c_ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            c_ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:        readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            arm_q      <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            arm_q      <= arm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_nios_qsys_pio_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_qsys_pio_in
//  Description : Self-checking bench for nios_qsys_pio_in. Three instances
//                (rising, falling, any edge) share one stimulus stream and are
//                compared each clock against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_qsys_pio_in;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;

    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    nios_qsys_pio_in #(.WIDTH(W), .EDGE_TYPE(0)) u_dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    nios_qsys_pio_in #(.WIDTH(W), .EDGE_TYPE(1)) u_dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    nios_qsys_pio_in #(.WIDTH(W), .EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    // ------------------------------------------------------------------
    // Reference model
    // hist holds the input values sampled at the last three edges (oldest
    // first); the DATA register shows the sample taken two edges back.
    // ------------------------------------------------------------------
    logic [W-1:0] hist [$];
    int           edges_since_reset;
    logic [W-1:0] m_mask [3];
    logic [W-1:0] m_cap  [3];
    logic [31:0]  m_rd   [3];

    function automatic logic [W-1:0] edge_of(int kind, logic [W-1:0] now_v,
                                             logic [W-1:0] before_v);
        if (kind == 0)      return now_v & ~before_v;
        else if (kind == 1) return ~now_v & before_v;
        else                return now_v ^ before_v;
    endfunction

    task automatic model_edge();
        logic [W-1:0] now_v, before_v, clr;
        logic         wr;
        if (reset) begin
            hist = '{W'(0), W'(0), W'(0)};
            edges_since_reset = 0;
            for (int i = 0; i < 3; i++) begin
                m_mask[i] = '0;
                m_cap[i]  = '0;
                m_rd[i]   = '0;
            end
            return;
        end
        now_v    = hist[1];
        before_v = hist[0];
        wr       = chipselect && !write_n;
        clr      = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
        for (int i = 0; i < 3; i++) begin
            case (address)
                2'd0:    m_rd[i] = {24'h0, now_v};
                2'd1:    m_rd[i] = {24'h0, m_mask[i]};
                2'd2:    m_rd[i] = {24'h0, m_cap[i]};
                default: m_rd[i] = 32'h0;
            endcase
            m_cap[i] = (m_cap[i] & ~clr) |
                       ((edges_since_reset >= 3) ? edge_of(i, now_v, before_v) : '0);
            if (wr && address == 2'd1) m_mask[i] = writedata[W-1:0];
        end
        if (edges_since_reset < 3) edges_since_reset++;
        void'(hist.pop_front());
        hist.push_back(in_port);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs present at the edge, then
    // compare all instances a little after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rd_rise",  rd0, m_rd[0]);
        check_eq("rd_fall",  rd1, m_rd[1]);
        check_eq("rd_any",   rd2, m_rd[2]);
        check_eq("irq_rise", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask[0])});
        check_eq("irq_fall", {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask[1])});
        check_eq("irq_any",  {31'h0, irq2}, {31'h0, |(m_cap[2] & m_mask[2])});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        hist = '{W'(0), W'(0), W'(0)};
        edges_since_reset = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;

        // Static-high input held through reset release: no capture.
        idle(3);
        check_eq("reset_rd",  rd0, 32'h0);
        check_eq("reset_irq", {31'h0, irq0}, 32'h0);
        reset = 1'b0;
        idle(6);
        check_eq("r031_data", rd0, 32'hFF);
        check_eq("r031_irq",  {31'h0, irq0}, 32'h0);
        address = 2'd2;
        tick();
        check_eq("r031_cap_rise", rd0, 32'h0);
        check_eq("r031_cap_any",  rd2, 32'h0);

        // Rising edge on bit 0 with IRQMASK=0x01.
        in_port = 8'h00;
        idle(4);
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h01);
        address = 2'd2;
        in_port = 8'h01;
        idle(2);
        check_eq("r029_irq_early", {31'h0, irq0}, 32'h0);
        tick();
        check_eq("r029_irq", {31'h0, irq0}, 32'h1);
        tick();
        check_eq("r029_cap", rd0, 32'h1);

        // New rising edge captured on the same edge as a W1C clear.
        in_port = 8'h00;
        idle(4);
        in_port = 8'h01;
        idle(2);
        wr(2'd2, 32'h01);
        check_eq("r030_irq", {31'h0, irq0}, 32'h1);
        tick();
        check_eq("r030_cap", rd0, 32'h1);

        // Masked capture, then unmask.
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h00);
        address = 2'd2;
        in_port = 8'h08;
        idle(4);
        check_eq("r032_cap", rd0, 32'h08);
        check_eq("r032_irq_masked", {31'h0, irq0}, 32'h0);
        wr(2'd1, 32'h08);
        check_eq("r032_irq", {31'h0, irq0}, 32'h1);

        // Writes to DATA and reserved are ignored.
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        tick();
        check_eq("r034_rsvd", rd0, 32'h0);
        address = 2'd1;
        tick();
        check_eq("r034_mask", rd0, 32'h08);

        // Any-edge instance: bit 5 toggles with clears in between.
        wr(2'd2, 32'hFF);
        address = 2'd2;
        in_port = 8'h28;
        idle(4);
        check_eq("r033_set_rise", rd2 & 32'h20, 32'h20);
        wr(2'd2, 32'h20);
        tick();
        check_eq("r033_clr1", rd2 & 32'h20, 32'h0);
        in_port = 8'h08;
        idle(4);
        check_eq("r033_set_fall", rd2 & 32'h20, 32'h20);
        wr(2'd2, 32'h20);
        tick();
        check_eq("r033_clr2", rd2 & 32'h20, 32'h0);

        // Mid-operation reset with a simultaneous write.
        in_port = 8'h09;
        idle(4);
        reset      = 1'b1;
        address    = 2'd1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'hFF;
        tick();
        check_eq("r027_irq", {31'h0, irq0}, 32'h0);
        check_eq("r027_irq_any", {31'h0, irq2}, 32'h0);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
        check_eq("r028_mask", rd0, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = ($urandom_range(0, 1) != 0) ? $urandom() : 32'h0;
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_qsys_pio_in.md
NIOS_QSYS_PIO_IN -- requirements
Module: nios_qsys_pio_in

Interface
REQ-001 Parameter WIDTH, default 8, meaning: number of input port bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, meaning: capture edge; 0 = rising, 1 = falling, 2 = any.
REQ-003 Port clk, input, 1: single clock for all logic; one clock domain only.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port address, input, 2: Avalon-MM register select.
REQ-006 Port chipselect, input, 1: Avalon-MM slave select.
REQ-007 Port write_n, input, 1: active-low write strobe.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port in_port, input, WIDTH: asynchronous external inputs.
REQ-010 Port readdata, output, 32: registered read data; unused upper bits are 0.
REQ-011 Port irq, output, 1: level interrupt, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a 2-FF synchronizer (sync1, sync2); a third register prev SHALL hold the prior sync2 value.
REQ-013 The edge term SHALL be: rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev, selected per EDGE_TYPE.
REQ-014 Register map SHALL be: addr 0 = DATA (sync2, read-only); addr 1 = IRQMASK (RW, WIDTH bits); addr 2 = EDGECAP (read, write-1-to-clear); addr 3 = reserved, reads 0.
REQ-015 A write SHALL occur on a clk edge with chipselect=1 and write_n=0.
REQ-016 Writes to addr 0 and addr 3 SHALL have no effect.
REQ-017 On an IRQMASK write, IRQMASK SHALL load writedata[WIDTH-1:0].
REQ-018 On an EDGECAP write, each EDGECAP bit SHALL clear where writedata has a 1 and SHALL be unchanged where it has a 0.
REQ-019 An EDGECAP bit SHALL set on the clock after its edge term is 1, and SHALL hold until cleared.
REQ-020 If a bit is being set and cleared on the same edge, the set SHALL win (bit = 1).
REQ-021 readdata SHALL update every clock from the address mux, independent of chipselect; reads SHALL have no side effects.
REQ-022 Read latency SHALL be 1: the value presented at address on edge k SHALL appear on readdata after edge k.
REQ-023 irq SHALL be the OR of (EDGECAP & IRQMASK), driven from registers only, with no path from in_port.
REQ-024 Edge-to-irq latency: if in_port changes before edge k, then sync2 changes after k+1, EDGECAP/irq assert after k+2, and a DATA read issued at k+1 returns the new value after k+2.
REQ-025 A 2-bit arm counter SHALL suppress edge capture until 3 clocks after reset deassertion, so a static-high input at reset does not produce a spurious edge.

Reset
REQ-026 While reset=1 at a clk edge, the following SHALL be 0: sync1, sync2, prev, IRQMASK, EDGECAP, readdata and the arm counter; irq SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL clear pending EDGECAP bits and deassert irq on the same edge.
REQ-028 Reset SHALL take priority over any simultaneous write.

Verification
REQ-029 Setup: WIDTH=8, EDGE_TYPE=0, IRQMASK=0x01. Stimulus: in_port 0x00->0x01 before edge k. Response: EDGECAP=0x01 and irq=1 after k+2; a read of addr 2 returns 0x00000001.
REQ-030 Stimulus: write addr 2 with 0x01 on the same edge as a new rising edge on bit 0. Response: EDGECAP bit 0 stays 1 and irq stays 1.
REQ-031 Stimulus: in_port=0xFF held through reset release. Response: EDGECAP stays 0x00 and irq stays 0; a read of addr 0 returns 0x000000FF.
REQ-032 Stimulus: IRQMASK=0x00, rising edge on bit 3. Response: EDGECAP=0x08 and irq=0. Then write IRQMASK=0x08. Response: irq=1 the next clock.
REQ-033 Stimulus: EDGE_TYPE=2, in_port bit 5 toggles 0->1->0 with two separate W1C clears in between. Response: EDGECAP bit 5 sets on each transition.
REQ-034 Stimulus: write 0xFFFFFFFF to addr 0 and to addr 3. Response: no register changes; addr 3 reads 0.
